// File: rtl/snax_tcdm_adapter_pkg.sv
// Shared constants and default bundled TCDM types for the SNAX TCDM port adapter.
// The default request/response structs match the adapter's default parameters
// (64-bit data, 48-bit address).
package snax_tcdm_adapter_pkg;

  localparam int unsigned DefDataWidth = 64;
  localparam int unsigned DefAddrWidth = 48;
  localparam int unsigned CoreIdWidth  = 5;

  // Accelerator traffic never carries atomics and never claims to be a core.
  localparam logic [3:0]             AMONone         = 4'h0;
  localparam logic [CoreIdWidth-1:0] UserCoreIdFixed = '0;
  localparam logic                   UserIsCoreFixed = 1'b0;

  typedef struct packed {
    logic [CoreIdWidth-1:0] core_id;
    logic                   is_core;
  } tcdm_user_t;

  typedef struct packed {
    logic                      write;
    logic [DefAddrWidth-1:0]   addr;
    logic [3:0]                amo;
    logic [DefDataWidth-1:0]   data;
    logic [DefDataWidth/8-1:0] strb;
    tcdm_user_t                user;
  } tcdm_req_chan_t;

  typedef struct packed {
    tcdm_req_chan_t q;
    logic           q_valid;
  } tcdm_req_default_t;

  typedef struct packed {
    logic [DefDataWidth-1:0] data;
  } tcdm_rsp_chan_t;

  typedef struct packed {
    logic           q_ready;
    logic           p_valid;
    tcdm_rsp_chan_t p;
  } tcdm_rsp_default_t;

endpackage

// File: rtl/snax_tcdm_port_fifo.sv
// One TCDM port: a non-fall-through request FIFO plus a read-outstanding limiter.
// Handshake: a transfer happens in a cycle where valid and ready are both high;
// the FIFO head (and its q_valid) stays stable until it is accepted, and the
// response side (p_valid) has no backpressure.
module snax_tcdm_port_fifo
  import snax_tcdm_adapter_pkg::*;
#(
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned AddrWidth      = 48,
  parameter int unsigned FifoDepth      = 2,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   i_push_valid,
  input  logic                   i_write,
  input  logic [AddrWidth-1:0]   i_addr,
  input  logic [DataWidth-1:0]   i_data,
  input  logic [DataWidth/8-1:0] i_strb,
  output logic                   o_push_ready,
  output logic                   o_q_valid,
  output logic                   o_q_write,
  output logic [AddrWidth-1:0]   o_q_addr,
  output logic [DataWidth-1:0]   o_q_data,
  output logic [DataWidth/8-1:0] o_q_strb,
  input  logic                   i_q_ready,
  input  logic                   i_p_valid,
  output logic                   o_empty,
  output logic                   o_cnt_zero,
  output logic                   o_err
);

  localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned CntW = $clog2(FifoDepth + 1);
  localparam int unsigned OutW = $clog2(MaxOutstanding + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(FifoDepth - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(FifoDepth);
  localparam logic [OutW-1:0] MaxOut  = OutW'(MaxOutstanding);

  typedef struct packed {
    logic                   write;
    logic [AddrWidth-1:0]   addr;
    logic [DataWidth-1:0]   data;
    logic [DataWidth/8-1:0] strb;
  } entry_t;

  entry_t          r_mem [FifoDepth];
  logic [PtrW-1:0] r_wptr, r_rptr;
  logic [CntW-1:0] r_count;
  logic [OutW-1:0] r_out;

  entry_t w_entry_in, w_head;
  logic   w_full, w_empty, w_push, w_pop, w_rd_hs;

  assign w_entry_in = '{write: i_write, addr: i_addr, data: i_data, strb: i_strb};
  assign w_head     = r_mem[r_rptr];
  assign w_full     = (r_count == FullCnt);
  assign w_empty    = (r_count == '0);
  // Full blocks a push even when the head leaves in the same cycle.
  assign w_push     = i_push_valid & ~w_full;
  assign o_q_valid  = ~w_empty & (w_head.write | (r_out < MaxOut));
  assign w_pop      = o_q_valid & i_q_ready;
  assign w_rd_hs    = w_pop & ~w_head.write;

  assign o_push_ready = ~w_full;
  assign o_q_write    = w_head.write;
  assign o_q_addr     = w_head.addr;
  assign o_q_data     = w_head.data;
  assign o_q_strb     = w_head.strb;
  assign o_empty      = w_empty;
  assign o_cnt_zero   = (r_out == '0);
  // A response with nothing outstanding cannot belong to any request we sent.
  assign o_err        = i_p_valid & (r_out == '0);

  // Entry storage: payload only, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= w_entry_in;
  end

  // Circular pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= (r_wptr == LastPtr) ? '0 : r_wptr + PtrW'(1);
      if (w_pop)  r_rptr <= (r_rptr == LastPtr) ? '0 : r_rptr + PtrW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CntW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CntW'(1);
    end
  end

  // In-flight read counter; a stray response leaves it at zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_out <= '0;
    end else if (w_rd_hs && !i_p_valid) begin
      r_out <= r_out + OutW'(1);
    end else if (!w_rd_hs && i_p_valid && (r_out != '0)) begin
      r_out <= r_out - OutW'(1);
    end
  end

endmodule

// File: rtl/snax_tcdm_port_adapter.sv
// Adapter between flat per-port accelerator TCDM signals and bundled
// tcdm_req_t/tcdm_rsp_t ports, with a registered all-drained barrier flag and a
// sticky error flag. Optional stall performance counter: SNAX_TCDM_ADAPTER_PERF_EN.
module snax_tcdm_port_adapter
  import snax_tcdm_adapter_pkg::*;
#(
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned NumPorts       = 24,
  parameter int unsigned TCDMAddrWidth  = 48,
  parameter int unsigned FifoDepth      = 2,
  parameter int unsigned MaxOutstanding = 4,
  parameter type tcdm_req_t = tcdm_req_default_t,
  parameter type tcdm_rsp_t = tcdm_rsp_default_t
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [NumPorts-1:0]                    acc_req_write_i,
  input  logic [NumPorts-1:0][TCDMAddrWidth-1:0] acc_req_addr_i,
  input  logic [NumPorts-1:0][DataWidth-1:0]     acc_req_data_i,
  input  logic [NumPorts-1:0][DataWidth/8-1:0]   acc_req_strb_i,
  input  logic [NumPorts-1:0]                    acc_req_valid_i,
  output logic [NumPorts-1:0]                    acc_req_ready_o,
  output logic [NumPorts-1:0]                    acc_rsp_valid_o,
  output logic [NumPorts-1:0][DataWidth-1:0]     acc_rsp_data_o,
  input  logic                                   csr_idle_i,
  output tcdm_req_t [NumPorts-1:0]               tcdm_req_o,
  input  tcdm_rsp_t [NumPorts-1:0]               tcdm_rsp_i,
  output logic                                   snax_barrier_o,
  output logic                                   err_o,
  input  logic                                   perf_clr_i,
  output logic [31:0]                            perf_stall_cnt_o
);

  logic [NumPorts-1:0] w_q_valid, w_empty, w_cnt_zero, w_err;
  logic                w_barrier_cond;
  logic                r_barrier, r_err;

  for (genvar g = 0; g < NumPorts; g++) begin : g_port
    logic                     w_write;
    logic [TCDMAddrWidth-1:0] w_addr;
    logic [DataWidth-1:0]     w_data;
    logic [DataWidth/8-1:0]   w_strb;
    tcdm_req_t                w_req;

    snax_tcdm_port_fifo #(
      .DataWidth      (DataWidth),
      .AddrWidth      (TCDMAddrWidth),
      .FifoDepth      (FifoDepth),
      .MaxOutstanding (MaxOutstanding)
    ) u_port_fifo (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .i_push_valid (acc_req_valid_i[g]),
      .i_write      (acc_req_write_i[g]),
      .i_addr       (acc_req_addr_i[g]),
      .i_data       (acc_req_data_i[g]),
      .i_strb       (acc_req_strb_i[g]),
      .o_push_ready (acc_req_ready_o[g]),
      .o_q_valid    (w_q_valid[g]),
      .o_q_write    (w_write),
      .o_q_addr     (w_addr),
      .o_q_data     (w_data),
      .o_q_strb     (w_strb),
      .i_q_ready    (tcdm_rsp_i[g].q_ready),
      .i_p_valid    (tcdm_rsp_i[g].p_valid),
      .o_empty      (w_empty[g]),
      .o_cnt_zero   (w_cnt_zero[g]),
      .o_err        (w_err[g])
    );

    // Bundle the FIFO head into the cluster request struct with fixed fields.
    always_comb begin
      w_req                = '0;
      w_req.q_valid        = w_q_valid[g];
      w_req.q.write        = w_write;
      w_req.q.addr         = w_addr;
      w_req.q.amo          = AMONone;
      w_req.q.data         = w_data;
      w_req.q.strb         = w_strb;
      w_req.q.user.core_id = UserCoreIdFixed;
      w_req.q.user.is_core = UserIsCoreFixed;
    end

    assign tcdm_req_o[g]      = w_req;
    assign acc_rsp_valid_o[g] = tcdm_rsp_i[g].p_valid;
    assign acc_rsp_data_o[g]  = tcdm_rsp_i[g].p.data;
  end

  assign w_barrier_cond = csr_idle_i & (&w_empty) & (&w_cnt_zero);

  // Barrier and sticky error flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_barrier <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_barrier <= w_barrier_cond;
      r_err     <= r_err | (|w_err);
    end
  end

  assign snax_barrier_o = r_barrier;
  assign err_o          = r_err;

`ifdef SNAX_TCDM_ADAPTER_PERF_EN
  logic        w_stall_any;
  logic [31:0] r_stall_cnt;

  // Any port offering a request that the interconnect refuses this cycle.
  always_comb begin
    w_stall_any = 1'b0;
    for (int i = 0; i < NumPorts; i++) begin
      w_stall_any = w_stall_any | (w_q_valid[i] & ~tcdm_rsp_i[i].q_ready);
    end
  end

  // Saturating stall counter; clear wins over increment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall_cnt <= '0;
    end else if (perf_clr_i) begin
      r_stall_cnt <= '0;
    end else if (w_stall_any && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt_o = r_stall_cnt;
`else
  logic w_unused_perf_clr;
  assign w_unused_perf_clr = perf_clr_i;
  assign perf_stall_cnt_o  = '0;
`endif

endmodule
